// File: rtl/uart_tx_sched.sv
// Transmit scheduler: buffers bytes in a FIFO and feeds them to a polled uart
// (data at addr 0, status at addr 1, status bit 7 = transmitter busy).
module uart_tx_sched #(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       u_cs,
  output logic                       u_we,
  output logic                       u_addr,
  output logic [7:0]                 u_dbw,
  input  logic [7:0]                 u_dbr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_CNT  = CW'(1'b1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1'b1);
  localparam logic [3:0]    GAP_LOAD = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POLL  = 2'd1,
    WRITE = 2'd2,
    GAP   = 2'd3
  } state_t;

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r, count_s;
  state_t        state_r, state_s;
  logic [3:0]    gap_r, gap_s;
  logic          cs_s, we_s, addr_s;
  logic [7:0]    dbw_s;
  logic          push_s, pop_s;
  logic          u_cs_r, u_we_r, u_addr_r;
  logic [7:0]    u_dbw_r;
  logic          in_ready_r, idle_r;
  logic          unused_dbr_s;

  // Only the busy flag of the status register matters.
  assign unused_dbr_s = ^u_dbr[6:0];

  assign push_s = in_valid && (count_r != FULL_CNT);
  assign pop_s  = (state_r == WRITE);

  // Next occupancy from this edge's push/pop pair.
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + ONE_CNT;
      2'b01:   count_s = count_r - ONE_CNT;
      default: count_s = count_r;
    endcase
  end

  // Next-state and next-output decode; the uart pins are registered from these.
  always_comb begin
    state_s = state_r;
    gap_s   = gap_r;
    cs_s    = 1'b0;
    we_s    = 1'b0;
    addr_s  = 1'b0;
    dbw_s   = 8'h00;
    case (state_r)
      IDLE: begin
        if (count_r != ZERO_CNT) begin
          state_s = POLL;
          cs_s    = 1'b1;
          addr_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      POLL: begin
        if (u_dbr[7]) begin
          state_s = GAP;
          gap_s   = GAP_LOAD;
        end else begin
          state_s = WRITE;
          cs_s    = 1'b1;
          we_s    = 1'b1;
          dbw_s   = mem_r[rd_ptr_r];
        end
      end
      WRITE: begin
        state_s = GAP;
        gap_s   = GAP_LOAD;
      end
      GAP: begin
        if (gap_r != 4'd0) begin
          gap_s = gap_r - 4'd1;
        end else if (count_r != ZERO_CNT) begin
          state_s = POLL;
          cs_s    = 1'b1;
          addr_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
        gap_s   = 4'd0;
      end
    endcase
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Control state, pointers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      gap_r      <= 4'd0;
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= ZERO_CNT;
      u_cs_r     <= 1'b0;
      u_we_r     <= 1'b0;
      u_addr_r   <= 1'b0;
      u_dbw_r    <= 8'h00;
      in_ready_r <= 1'b1;
      idle_r     <= 1'b1;
    end else begin
      state_r    <= state_s;
      gap_r      <= gap_s;
      count_r    <= count_s;
      u_cs_r     <= cs_s;
      u_we_r     <= we_s;
      u_addr_r   <= addr_s;
      u_dbw_r    <= dbw_s;
      in_ready_r <= (count_s != FULL_CNT);
      idle_r     <= (state_s == IDLE) && (count_s == ZERO_CNT);
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_PTR;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end
    end
  end

  assign in_ready = in_ready_r;
  assign u_cs     = u_cs_r;
  assign u_we     = u_we_r;
  assign u_addr   = u_addr_r;
  assign u_dbw    = u_dbw_r;
  assign count    = count_r;
  assign idle     = idle_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: cycle vector table plus directed
// sequences against a small polled-uart model.
module tb_uart_tx_sched;

  localparam int DEPTH = 8;
  localparam int GAP   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       u_cs, u_we, u_addr;
  logic [7:0] u_dbw;
  logic [7:0] u_dbr;
  logic [3:0] count;
  logic       idle;

  int n_cmp = 0;
  int n_bad = 0;

  // uart model state (written only by the model process)
  int         cyc = 0;
  int         cs_cnt = 0;
  int         poll_cnt = 0;
  int         write_cnt = 0;
  int         viol = 0;
  bit         last_busy = 1'b0;
  int         poll_cyc [256];
  int         wr_cyc [256];
  logic [7:0] wr_log [256];

  // uart behaviour knobs (written only by the stimulus process)
  bit busy_all = 1'b0;
  int busy_polls = 0;
  int poll_base = 0;

  uart_tx_sched #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .u_cs(u_cs), .u_we(u_we), .u_addr(u_addr),
    .u_dbw(u_dbw), .u_dbr(u_dbr), .count(count), .idle(idle)
  );

  always #5 clk = ~clk;

  // Status register: busy in bit 7, noise in the low bits that must be ignored.
  assign u_dbr = (busy_all || ((poll_cnt - poll_base) < busy_polls)) ? 8'h80 : 8'h05;

  always @(posedge clk) begin
    if (!rst) begin
      cyc <= cyc + 1;
      if (u_cs) cs_cnt <= cs_cnt + 1;
      if (u_cs && !u_we && u_addr) begin
        poll_cyc[poll_cnt[7:0]] <= cyc;
        poll_cnt  <= poll_cnt + 1;
        last_busy <= u_dbr[7];
      end
      if (u_cs && u_we && !u_addr) begin
        wr_log[write_cnt[7:0]] <= u_dbw;
        wr_cyc[write_cnt[7:0]] <= cyc;
        write_cnt <= write_cnt + 1;
        if (last_busy) viol <= viol + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_writes(input int target, input int maxc, input string name);
    for (int i = 0; i < maxc && write_cnt < target; i++) @(negedge clk);
    check(name, write_cnt, target);
  endtask

  task automatic wait_idle(input int maxc, input string name);
    for (int i = 0; i < maxc && idle !== 1'b1; i++) @(negedge clk);
    check(name, {31'd0, idle}, 32'd1);
  endtask

  task automatic wait_write_cycle(input int maxc, input string name);
    for (int i = 0; i < maxc && !(u_cs === 1'b1 && u_we === 1'b1); i++) @(negedge clk);
    check(name, {31'd0, u_cs & u_we}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] din;
    logic       vld;
    logic       cs;
    logic       we;
    logic       addr;
    logic [7:0] dbw;
    logic [3:0] cnt;
    logic       rdy;
    logic       idl;
  } vec_t;

  vec_t vec [16];

  initial begin
    int wb;
    int cc;

    // row i: inputs before edge i, outputs expected after edge i
    vec[0]  = '{8'h7B, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd1, 1'b1, 1'b0};
    vec[1]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 4'd1, 1'b1, 1'b0};
    vec[2]  = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h7B, 4'd1, 1'b1, 1'b0};
    vec[3]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0};
    vec[4]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0};
    vec[5]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b1};
    vec[6]  = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd1, 1'b1, 1'b0};
    vec[7]  = '{8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 4'd2, 1'b1, 1'b0};
    vec[8]  = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 4'd2, 1'b1, 1'b0};
    vec[9]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd1, 1'b1, 1'b0};
    vec[10] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd1, 1'b1, 1'b0};
    vec[11] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 4'd1, 1'b1, 1'b0};
    vec[12] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22, 4'd1, 1'b1, 1'b0};
    vec[13] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0};
    vec[14] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0};
    vec[15] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b1};

    rst      = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs", {31'd0, u_cs}, 32'd0);
    check("rst_we", {31'd0, u_we}, 32'd0);
    check("rst_dbw", {24'd0, u_dbw}, 32'd0);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_idle", {31'd0, idle}, 32'd1);
    rst = 1'b0;

    // 1: reset mid-cycle while the scheduler is polling, then stay quiet
    busy_all = 1'b1;
    push(8'hC3);
    for (int i = 0; i < 20 && u_cs !== 1'b1; i++) @(negedge clk);
    check("t1_cs_seen", {31'd0, u_cs}, 32'd1);
    rst = 1'b1;
    #1;
    check("t1_cs_async", {31'd0, u_cs}, 32'd0);
    check("t1_ready_async", {31'd0, in_ready}, 32'd1);
    check("t1_count_async", {28'd0, count}, 32'd0);
    check("t1_idle_async", {31'd0, idle}, 32'd1);
    busy_all = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cc = cs_cnt;
    repeat (20) @(negedge clk);
    check("t1_no_cs", cs_cnt - cc, 32'd0);
    check("t1_idle", {31'd0, idle}, 32'd1);

    // 2: cycle-exact single byte, then two bytes back to back
    for (int i = 0; i < 16; i++) begin
      in_data  = vec[i].din;
      in_valid = vec[i].vld;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {15'd0, u_cs, u_we, u_addr, u_dbw, count, in_ready, idle},
            {15'd0, vec[i].cs, vec[i].we, vec[i].addr, vec[i].dbw, vec[i].cnt, vec[i].rdy, vec[i].idl});
    end
    in_valid = 1'b0;

    // 3: three busy polls then free
    wb         = write_cnt;
    poll_base  = poll_cnt;
    busy_polls = 3;
    push(8'h3E);
    wait_writes(wb + 1, 100, "t3_write_done");
    check("t3_polls", poll_cnt - poll_base, 32'd4);
    for (int i = 0; i < 3; i++)
      check($sformatf("t3_poll_gap%0d", i),
            poll_cyc[(poll_base + i + 1) & 255] - poll_cyc[(poll_base + i) & 255], GAP + 1);
    check("t3_write_after_poll", wr_cyc[wb & 255] - poll_cyc[(poll_base + 3) & 255], 32'd1);
    check("t3_data", {24'd0, wr_log[wb & 255]}, 32'h3E);
    wait_idle(50, "t3_idle");
    busy_polls = 0;

    // 4: fill past full while busy, drain in order, then across the wrap
    busy_all = 1'b1;
    wb = write_cnt;
    for (int i = 1; i <= 9; i++) begin
      in_data  = 8'(i);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("t4_count_full", {28'd0, count}, 32'd8);
    check("t4_ready_full", {31'd0, in_ready}, 32'd0);
    check("t4_no_write_busy", write_cnt - wb, 32'd0);
    busy_all = 1'b0;
    wait_writes(wb + 8, 200, "t4_drain");
    for (int i = 0; i < 8; i++)
      check($sformatf("t4_order%0d", i), {24'd0, wr_log[(wb + i) & 255]}, i + 1);
    wait_idle(50, "t4_idle");
    push(8'hFF);
    push(8'h00);
    wait_writes(wb + 10, 100, "t4_wrap_done");
    check("t4_wrap_ff", {24'd0, wr_log[(wb + 8) & 255]}, 32'hFF);
    check("t4_wrap_00", {24'd0, wr_log[(wb + 9) & 255]}, 32'h00);
    wait_idle(50, "t4_idle2");

    // 5: push landing on the pop edge of a WRITE with three queued
    busy_all = 1'b1;
    wb = write_cnt;
    push(8'h31);
    push(8'h32);
    push(8'h33);
    check("t5_count3", {28'd0, count}, 32'd3);
    busy_all = 1'b0;
    wait_write_cycle(50, "t5_write_seen");
    in_data  = 8'hAA;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("t5_count_same", {28'd0, count}, 32'd3);
    wait_writes(wb + 4, 100, "t5_done");
    check("t5_b0", {24'd0, wr_log[wb & 255]}, 32'h31);
    check("t5_b1", {24'd0, wr_log[(wb + 1) & 255]}, 32'h32);
    check("t5_b2", {24'd0, wr_log[(wb + 2) & 255]}, 32'h33);
    check("t5_b3", {24'd0, wr_log[(wb + 3) & 255]}, 32'hAA);
    wait_idle(50, "t5_idle");

    // 6: reset in the middle of a WRITE with four queued
    busy_all = 1'b1;
    push(8'h61);
    push(8'h62);
    push(8'h63);
    push(8'h64);
    busy_all = 1'b0;
    wait_write_cycle(50, "t6_write_seen");
    check("t6_count4", {28'd0, count}, 32'd4);
    wb  = write_cnt;
    rst = 1'b1;
    #1;
    check("t6_cs_async", {31'd0, u_cs}, 32'd0);
    check("t6_we_async", {31'd0, u_we}, 32'd0);
    check("t6_count_async", {28'd0, count}, 32'd0);
    check("t6_idle_async", {31'd0, idle}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    check("t6_aborted", write_cnt - wb, 32'd0);
    push(8'h55);
    wait_writes(wb + 1, 50, "t6_write_done");
    check("t6_first", {24'd0, wr_log[wb & 255]}, 32'h55);
    repeat (10) @(negedge clk);
    check("t6_only_one", write_cnt - wb, 32'd1);
    check("t6_idle", {31'd0, idle}, 32'd1);
    check("no_write_while_busy", viol, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
